// File: rtl/mmio_responder.sv
// mmio_responder
//   Memory-mapped I/O slave for a small CPU bus. Provides an 8-bit LED
//   register, synchronized slide-switch readback, sticky key-press flags
//   (clear-on-read) and a free-running 16-bit cycle counter that the CPU
//   can preload.
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   reset       asynchronous, active-high reset
//   mem_cmd     2'b00 none, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 none
//   mem_addr    9-bit bus address
//   write_data  16-bit store data
//   SW          raw asynchronous slide switches
//   KEY_n       raw asynchronous push buttons, active-low
//   read_data   combinational load data (zero unless a mapped MREAD)
//   io_hit      high while the current MREAD targets a mapped address
//   LEDR        LED register contents
module mmio_responder #(
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] SW_ADDR  = 9'h140,
    parameter logic [8:0] KEY_ADDR = 9'h141,
    parameter logic [8:0] CNT_ADDR = 9'h142
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [9:0]  SW,
    input  logic [1:0]  KEY_n,
    output logic [15:0] read_data,
    output logic        io_hit,
    output logic [7:0]  LEDR
);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    logic        is_read;
    logic        is_write;
    logic        wr_led;
    logic        wr_cnt;
    logic        rd_key;

    logic [9:0]  sw_s1;
    logic [9:0]  sw_s2;
    logic [1:0]  key_s1;
    logic [1:0]  key_s2;
    logic [1:0]  key_hist;
    logic [1:0]  press;
    logic [1:0]  pressed;
    logic [15:0] counter;

    assign is_read  = (mem_cmd == CMD_READ);
    assign is_write = (mem_cmd == CMD_WRITE);
    assign wr_led   = is_write && (mem_addr == LED_ADDR);
    assign wr_cnt   = is_write && (mem_addr == CNT_ADDR);
    assign rd_key   = is_read  && (mem_addr == KEY_ADDR);

    // Active-low buttons: a press is the synchronized level going 1 -> 0.
    assign press = key_hist & ~key_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
        end
    end

    // Key pipeline resets to "released" so deasserting reset cannot
    // look like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1   <= 2'b11;
            key_s2   <= 2'b11;
            key_hist <= 2'b11;
        end else begin
            key_s1   <= KEY_n;
            key_s2   <= key_s1;
            key_hist <= key_s2;
        end
    end

    // Clear-on-read, but a press detected in the same cycle survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pressed <= 2'b00;
        end else begin
            pressed <= (rd_key ? 2'b00 : pressed) | press;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            LEDR <= 8'h00;
        end else if (wr_led) begin
            LEDR <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= 16'h0000;
        end else if (wr_cnt) begin
            counter <= write_data;
        end else begin
            counter <= counter + 16'h0001;
        end
    end

    always_comb begin
        read_data = 16'h0000;
        io_hit    = 1'b0;
        if (is_read) begin
            case (mem_addr)
                LED_ADDR: begin
                    read_data = {8'h00, LEDR};
                    io_hit    = 1'b1;
                end
                SW_ADDR: begin
                    read_data = {6'b000000, sw_s2};
                    io_hit    = 1'b1;
                end
                KEY_ADDR: begin
                    read_data = {14'b0, pressed};
                    io_hit    = 1'b1;
                end
                CNT_ADDR: begin
                    read_data = counter;
                    io_hit    = 1'b1;
                end
                default: begin
                    read_data = 16'h0000;
                    io_hit    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

    localparam logic [8:0] A_LED = 9'h100;
    localparam logic [8:0] A_SW  = 9'h140;
    localparam logic [8:0] A_KEY = 9'h141;
    localparam logic [8:0] A_CNT = 9'h142;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WR   = 2'b10;
    localparam logic [1:0] RSV  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [9:0]  SW;
    logic [1:0]  KEY_n;
    logic [15:0] read_data;
    logic        io_hit;
    logic [7:0]  LEDR;

    int checks = 0;
    int errors = 0;

    mmio_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .SW         (SW),
        .KEY_n      (KEY_n),
        .read_data  (read_data),
        .io_hit     (io_hit),
        .LEDR       (LEDR)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    // Reference model: register values plus a short history of what was
    // on SW / KEY_n at the last few rising edges (index 0 = most recent).
    logic [7:0]  m_led;
    logic [15:0] m_cnt;
    logic [1:0]  m_pressed;
    logic [9:0]  sw_q  [3];
    logic [1:0]  key_q [3];

    task automatic model_reset();
        m_led     = 8'h00;
        m_cnt     = 16'h0000;
        m_pressed = 2'b00;
        for (int i = 0; i < 3; i++) begin
            sw_q[i]  = '0;
            key_q[i] = 2'b11;
        end
    endtask

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_step();
        logic [1:0] newly;
        // released three edges ago, held two edges ago -> a new press
        newly = key_q[2] & ~key_q[1];
        if (mem_cmd == WR && mem_addr == A_LED) m_led = write_data[7:0];
        if (mem_cmd == WR && mem_addr == A_CNT) m_cnt = write_data;
        else                                     m_cnt = m_cnt + 16'd1;
        if (mem_cmd == RD && mem_addr == A_KEY) m_pressed = 2'b00;
        m_pressed = m_pressed | newly;
        for (int i = 2; i > 0; i--) begin
            sw_q[i]  = sw_q[i-1];
            key_q[i] = key_q[i-1];
        end
        sw_q[0]  = SW;
        key_q[0] = KEY_n;
    endtask

    function automatic logic [16:0] model_read(input logic [1:0] c, input logic [8:0] a);
        if (c != RD) return 17'h0;
        case (a)
            A_LED:   return {1'b1, 8'h00, m_led};
            A_SW:    return {1'b1, 6'h00, sw_q[1]};
            A_KEY:   return {1'b1, 14'h0, m_pressed};
            A_CNT:   return {1'b1, m_cnt};
            default: return 17'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a bus cycle (called just after a rising edge) and wait until
    // mid-cycle so the caller can sample combinational outputs.
    task automatic apply(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        apply(c, a, d);
        finish_cycle();
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [9:0]  sw;
        logic [15:0] rd;
        logic        hit;
        logic [7:0]  led;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [8:0] addr_pick [4];
        logic [1:0] rc;
        logic [8:0] ra;
        logic [16:0] exp;

        addr_pick[0] = A_LED;
        addr_pick[1] = A_SW;
        addr_pick[2] = A_KEY;
        addr_pick[3] = A_CNT;

        tbl[0]  = '{WR,   A_LED, 16'hABCD, 10'h000, 16'h0000, 1'b0, 8'h00};
        tbl[1]  = '{RD,   A_LED, 16'h0000, 10'h000, 16'h00CD, 1'b1, 8'hCD};
        tbl[2]  = '{WR,   A_CNT, 16'hFFFE, 10'h000, 16'h0000, 1'b0, 8'hCD};
        tbl[3]  = '{RD,   A_CNT, 16'h0000, 10'h000, 16'hFFFE, 1'b1, 8'hCD};
        tbl[4]  = '{RD,   A_CNT, 16'h0000, 10'h000, 16'hFFFF, 1'b1, 8'hCD};
        tbl[5]  = '{RD,   A_CNT, 16'h0000, 10'h000, 16'h0000, 1'b1, 8'hCD};
        tbl[6]  = '{RD,   9'h0FF, 16'h0000, 10'h000, 16'h0000, 1'b0, 8'hCD};
        tbl[7]  = '{NONE, A_SW,  16'h0000, 10'h00A, 16'h0000, 1'b0, 8'hCD};
        tbl[8]  = '{RD,   A_SW,  16'h0000, 10'h00A, 16'h0000, 1'b1, 8'hCD};
        tbl[9]  = '{RD,   A_SW,  16'h0000, 10'h00A, 16'h000A, 1'b1, 8'hCD};
        tbl[10] = '{WR,   A_SW,  16'h03FF, 10'h00A, 16'h0000, 1'b0, 8'hCD};
        tbl[11] = '{RD,   A_SW,  16'h0000, 10'h00A, 16'h000A, 1'b1, 8'hCD};
        tbl[12] = '{RD,   A_KEY, 16'h0000, 10'h00A, 16'h0000, 1'b1, 8'hCD};
        tbl[13] = '{RSV,  A_LED, 16'h5555, 10'h00A, 16'h0000, 1'b0, 8'hCD};
        tbl[14] = '{WR,   9'h0FF, 16'h1234, 10'h00A, 16'h0000, 1'b0, 8'hCD};
        tbl[15] = '{RD,   A_LED, 16'h0000, 10'h00A, 16'h00CD, 1'b1, 8'hCD};

        reset      = 1'b1;
        mem_cmd    = NONE;
        mem_addr   = '0;
        write_data = '0;
        SW         = '0;
        KEY_n      = 2'b11;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        mem_cmd  = RD;
        mem_addr = A_CNT;
        #1;
        chk("reset_ledr", {8'h00, LEDR}, 16'h0000);
        chk("reset_cnt", read_data, 16'h0000);
        reset = 1'b0;
        #1;

        // directed table
        for (int i = 0; i < 16; i++) begin
            SW = tbl[i].sw;
            KEY_n = 2'b11;
            apply(tbl[i].cmd, tbl[i].addr, tbl[i].wd);
            chk($sformatf("tbl%0d_rd", i), read_data, tbl[i].rd);
            chk($sformatf("tbl%0d_hit", i), {15'h0, io_hit}, {15'h0, tbl[i].hit});
            chk($sformatf("tbl%0d_led", i), {8'h00, LEDR}, {8'h00, tbl[i].led});
            finish_cycle();
        end

        // key 0 held low for 3 cycles, then clear-on-read
        KEY_n = 2'b10;
        repeat (3) bus(NONE, 9'h000, 16'h0);
        KEY_n = 2'b11;
        repeat (4) bus(NONE, 9'h000, 16'h0);
        apply(RD, A_KEY, 16'h0);
        chk("key0_first_read", read_data, 16'h0001);
        finish_cycle();
        apply(RD, A_KEY, 16'h0);
        chk("key0_second_read", read_data, 16'h0000);
        finish_cycle();

        // key 1 press detected in the same cycle as a clearing read
        KEY_n = 2'b01;
        repeat (2) bus(NONE, 9'h000, 16'h0);
        apply(RD, A_KEY, 16'h0);
        chk("key1_coincident_read", read_data, 16'h0000);
        finish_cycle();
        apply(RD, A_KEY, 16'h0);
        chk("key1_set_wins", read_data, 16'h0002);
        finish_cycle();
        KEY_n = 2'b11;
        repeat (4) bus(NONE, 9'h000, 16'h0);
        apply(RD, A_KEY, 16'h0);
        chk("key1_release_no_press", read_data, 16'h0000);
        finish_cycle();

        // reset mid-operation with LEDR=0x14 and both keys flagged
        KEY_n = 2'b00;
        repeat (3) bus(NONE, 9'h000, 16'h0);
        KEY_n = 2'b11;
        repeat (3) bus(NONE, 9'h000, 16'h0);
        bus(WR, A_LED, 16'h0014);
        apply(NONE, 9'h000, 16'h0);
        chk("pre_reset_led", {8'h00, LEDR}, 16'h0014);
        finish_cycle();
        mem_cmd    = WR;
        mem_addr   = A_LED;
        write_data = 16'h00FF;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_led", {8'h00, LEDR}, 16'h0000);
        mem_cmd  = RD;
        mem_addr = A_KEY;
        #1;
        chk("rst_pressed", read_data, 16'h0000);
        mem_addr = A_CNT;
        #1;
        chk("rst_cnt", read_data, 16'h0000);
        mem_cmd  = WR;
        mem_addr = A_LED;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        mem_cmd  = RD;
        mem_addr = A_CNT;
        reset    = 1'b0;
        #1;
        chk("post_rst_cnt0", read_data, 16'h0000);
        chk("post_rst_led", {8'h00, LEDR}, 16'h0000);
        finish_cycle();
        apply(RD, A_CNT, 16'h0);
        chk("post_rst_cnt1", read_data, 16'h0001);
        finish_cycle();
        repeat (4) bus(NONE, 9'h000, 16'h0);
        apply(RD, A_KEY, 16'h0);
        chk("post_rst_no_press", read_data, 16'h0000);
        finish_cycle();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
            if ($urandom_range(0, 5) == 0) KEY_n = 2'($urandom);
            rc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) < 4) ra = addr_pick[$urandom_range(0, 3)];
            else                          ra = 9'($urandom);
            apply(rc, ra, 16'($urandom));
            exp = model_read(rc, ra);
            chk($sformatf("rnd%0d_rd", n), read_data, exp[15:0]);
            chk($sformatf("rnd%0d_hit", n), {15'h0, io_hit}, {15'h0, exp[16]});
            chk($sformatf("rnd%0d_led", n), {8'h00, LEDR}, {8'h00, m_led});
            finish_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
